cordic_engine_param: RTL and testbench

//  Parametrised iterative CORDIC engine, successor to the fixed 8-step Q1.15 rotator.

---
 rtl/cordic_pkg.sv | 38 +++
 rtl/cordic_gain_comp.sv | 36 +++
 rtl/cordic_engine_param.sv | 150 +++++++++++++++
 tb/tb_cordic_engine_param.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared CORDIC types, arctangent table and gain constant helpers
package cordic_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        ITER,
        SCALE,
        DONE
    } cordic_state_e;

    // atan(2^-i) as a 32-bit binary angle, 2^32 == 2*pi
    localparam logic [31:0] ATAN_LUT [0:23] = '{
        32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4,
        32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
        32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
        32'h00028BE6, 32'h000145F3, 32'h0000A2FA, 32'h0000517D,
        32'h000028BE, 32'h0000145F, 32'h00000A30, 32'h00000518,
        32'h0000028C, 32'h00000146, 32'h000000A3, 32'h00000051
    };

    function automatic logic [31:0] atan_entry(input int i, input int bits);
        logic [32:0] t;
        t = {1'b0, ATAN_LUT[i]} + (33'd1 << (31 - bits));
        return 32'(t >> (32 - bits));
    endfunction

    // Inverse of the accumulated micro-rotation gain, Q1.31
    function automatic logic [31:0] cordic_kinv(input int n);
        real k;
        k = 1.0;
        for (int i = 0; i < n; i++) begin
            k = k / $sqrt(1.0 + 1.0 / (4.0 ** i));
        end
        return 32'($rtoi(k * 2147483648.0 + 0.5));
    endfunction

endpackage

// File: rtl/cordic_gain_comp.sv
// rtl/cordic_gain_comp.sv - multiply one channel by KINV, round half-up and saturate
module cordic_gain_comp
    import cordic_pkg::*;
#(
    parameter int IW    = 20,
    parameter int WIDTH = 16,
    parameter int FRAC  = 33
) (
    input  logic signed [IW-1:0]    din,
    input  logic        [31:0]      kinv,
    output logic signed [WIDTH-1:0] dout
);

    localparam int PW = IW + 33;
    localparam longint MAXL = (longint'(1) << (WIDTH - 1)) - 1;
    localparam logic signed [PW-1:0] MAXV = PW'(MAXL);
    localparam logic signed [PW-1:0] MINV = ~MAXV;

    logic signed [32:0]   k_s;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] scaled;

    always_comb begin
        k_s    = {1'b0, kinv};
        prod   = PW'(din) * PW'(k_s);
        scaled = (prod + (PW'(1) <<< (FRAC - 1))) >>> FRAC;
        if (scaled > MAXV) begin
            dout = MAXV[WIDTH-1:0];
        end else if (scaled < MINV) begin
            dout = MINV[WIDTH-1:0];
        end else begin
            dout = scaled[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/cordic_engine_param.sv
// rtl/cordic_engine_param.sv - iterative rotation/vectoring CORDIC with quadrant fold and gain compensation
module cordic_engine_param
    import cordic_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int ANGLE_W = 16,
    parameter int ITERS   = 16,
    parameter int GUARD   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               mode,
    input  logic [WIDTH-1:0]   x_in,
    input  logic [WIDTH-1:0]   y_in,
    input  logic [ANGLE_W-1:0] phi,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   x_out,
    output logic [WIDTH-1:0]   y_out,
    output logic [ANGLE_W-1:0] z_out
);

    localparam int IW = WIDTH + 2 + GUARD;
    localparam int ZW = ANGLE_W + GUARD;
    localparam logic [31:0] KINV = cordic_kinv(ITERS);
    localparam logic signed [ZW-1:0] HALF_PI = {2'b01, {(ZW-2){1'b0}}};
    localparam logic [ZW-1:0] Z_HALF_LSB = ZW'(1 << (GUARD - 1));
    localparam logic [4:0] LAST = 5'(ITERS - 1);

    cordic_state_e state_q, state_d;
    logic mode_q, mode_d;
    logic signed [IW-1:0] x_q, x_d, y_q, y_d, x_sh, y_sh;
    logic signed [ZW-1:0] z_q, z_d, atan_z, z_rnd;
    logic [4:0] i_q, i_d;
    logic signed [WIDTH-1:0] xo_q, xo_d, yo_q, yo_d, x_gain, y_gain;
    logic [ANGLE_W-1:0] zo_q, zo_d;
    logic dir_pos;

    cordic_gain_comp #(.IW(IW), .WIDTH(WIDTH), .FRAC(31 + GUARD)) u_gain_x (
        .din(x_q), .kinv(KINV), .dout(x_gain)
    );
    cordic_gain_comp #(.IW(IW), .WIDTH(WIDTH), .FRAC(31 + GUARD)) u_gain_y (
        .din(y_q), .kinv(KINV), .dout(y_gain)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        i_d     = i_q;
        xo_d    = xo_q;
        yo_d    = yo_q;
        zo_d    = zo_q;
        x_sh    = x_q >>> i_q;
        y_sh    = y_q >>> i_q;
        atan_z  = ZW'(atan_entry(int'(i_q), ZW));
        z_rnd   = z_q + Z_HALF_LSB;
        dir_pos = mode_q ? y_q[IW-1] : ~z_q[ZW-1];

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mode_d  = mode;
                    x_d     = {{2{x_in[WIDTH-1]}}, x_in, {GUARD{1'b0}}};
                    y_d     = {{2{y_in[WIDTH-1]}}, y_in, {GUARD{1'b0}}};
                    z_d     = {phi, {GUARD{1'b0}}};
                    state_d = PRE;
                end
            end
            PRE: begin
                i_d     = '0;
                state_d = ITER;
                // Bring the operand into the +/-pi/2 convergence range first
                if (!mode_q) begin
                    case (z_q[ZW-1 -: 2])
                        2'b01: begin x_d = -y_q; y_d = x_q;  z_d = z_q - HALF_PI; end
                        2'b10: begin x_d = y_q;  y_d = -x_q; z_d = z_q + HALF_PI; end
                        default: ;
                    endcase
                end else if (x_q[IW-1]) begin
                    if (!y_q[IW-1]) begin
                        x_d = y_q;  y_d = -x_q; z_d = HALF_PI;
                    end else begin
                        x_d = -y_q; y_d = x_q;  z_d = -HALF_PI;
                    end
                end else begin
                    z_d = '0;
                end
            end
            ITER: begin
                if (dir_pos) begin
                    x_d = x_q - y_sh;
                    y_d = y_q + x_sh;
                    z_d = z_q - atan_z;
                end else begin
                    x_d = x_q + y_sh;
                    y_d = y_q - x_sh;
                    z_d = z_q + atan_z;
                end
                i_d = i_q + 5'd1;
                if (i_q == LAST) state_d = SCALE;
            end
            SCALE: begin
                xo_d    = x_gain;
                yo_d    = y_gain;
                zo_d    = ANGLE_W'(z_rnd >>> GUARD);
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            i_q     <= '0;
            xo_q    <= '0;
            yo_q    <= '0;
            zo_q    <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            i_q     <= i_d;
            xo_q    <= xo_d;
            yo_q    <= yo_d;
            zo_q    <= zo_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign x_out     = xo_q;
    assign y_out     = yo_q;
    assign z_out     = zo_q;

endmodule

// File: tb/tb_cordic_engine_param.sv
// tb/tb_cordic_engine_param.sv - randomized and directed checks against a floating-point CORDIC reference
module tb_cordic_engine_param;

    localparam int  WIDTH   = 16;
    localparam int  ANGLE_W = 16;
    localparam int  ITERS   = 16;
    localparam int  GUARD   = 2;
    localparam int  TOL     = 4;
    localparam real PI      = 3.14159265358979323846;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic               mode;
    logic [WIDTH-1:0]   x_in;
    logic [WIDTH-1:0]   y_in;
    logic [ANGLE_W-1:0] phi;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   x_out;
    logic [WIDTH-1:0]   y_out;
    logic [ANGLE_W-1:0] z_out;

    int n_vec = 0;
    int n_err = 0;

    cordic_engine_param #(
        .WIDTH(WIDTH), .ANGLE_W(ANGLE_W), .ITERS(ITERS), .GUARD(GUARD)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
        .x_in(x_in), .y_in(y_in), .phi(phi),
        .out_valid(out_valid), .out_ready(out_ready),
        .x_out(x_out), .y_out(y_out), .z_out(z_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp, input int tol, input bit wrap);
        int d;
        n_vec++;
        d = got - exp;
        if (wrap) begin
            d = ((d % 65536) + 65536) % 65536;
            if (d >= 32768) d -= 65536;
        end
        if (d > tol || d < -tol) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
        end
    endtask

    function automatic int rnd_sat(input real v);
        real r;
        r = $floor(v + 0.5);
        if (r > 32767.0) return 32767;
        if (r < -32768.0) return -32768;
        return $rtoi(r);
    endfunction

    task automatic model(input bit m, input int xi, input int yi, input int ph,
                         output int ex, output int ey, output int ez);
        real a;
        if (!m) begin
            a  = real'(ph) * PI / 32768.0;
            ex = rnd_sat(real'(xi) * $cos(a) - real'(yi) * $sin(a));
            ey = rnd_sat(real'(xi) * $sin(a) + real'(yi) * $cos(a));
            ez = 0;
        end else begin
            ex = rnd_sat($sqrt(real'(xi) * real'(xi) + real'(yi) * real'(yi)));
            ey = 0;
            ez = $rtoi($floor($atan2(real'(yi), real'(xi)) * 32768.0 / PI + 0.5));
        end
    endtask

    task automatic send(input bit m, input int xi, input int yi, input int ph);
        chk("in_ready_idle", int'(in_ready), 1, 0, 1'b0);
        mode     = m;
        x_in     = WIDTH'(xi);
        y_in     = WIDTH'(yi);
        phi      = ANGLE_W'(ph);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat, output bit ok);
        lat = 0;
        ok  = 1'b0;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) ok = 1'b1;
        end
        if (!ok) chk("timeout", 0, 1, 0, 1'b0);
    endtask

    task automatic check_out(input string name, input int ex, input int ey, input int ez, input int xtol);
        chk({name, "_x"}, int'($signed(x_out)), ex, xtol, 1'b0);
        chk({name, "_y"}, int'($signed(y_out)), ey, TOL, 1'b0);
        chk({name, "_z"}, int'(z_out), ez, TOL, 1'b1);
    endtask

    task automatic txn(input string name, input bit m, input int xi, input int yi, input int ph,
                       input int xtol, output int lat);
        int ex, ey, ez;
        bit ok;
        model(m, xi, yi, ph, ex, ey, ez);
        send(m, xi, yi, ph);
        wait_out(lat, ok);
        if (ok) check_out(name, ex, ey, ez, xtol);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int lat, ex, ey, ez, xi, yi, ph;
        bit ok, seen;

        rst = 1'b1; in_valid = 1'b0; mode = 1'b0; out_ready = 1'b1;
        x_in = '0; y_in = '0; phi = '0;
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1, 0, 1'b0);
        chk("rst_out_valid", int'(out_valid), 0, 0, 1'b0);
        chk("rst_x_out", int'(x_out), 0, 0, 1'b0);
        chk("rst_y_out", int'(y_out), 0, 0, 1'b0);
        chk("rst_z_out", int'(z_out), 0, 0, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        txn("rot_pi4", 1'b0, 16'h4000, 0, 16'h2000, TOL, lat);
        chk("latency", lat, ITERS + 2, 0, 1'b0);
        txn("rot_mpi", 1'b0, 16'h4000, 0, -32768, TOL, lat);
        txn("vec_345", 1'b1, 16'h3000, 16'h4000, 0, TOL, lat);
        txn("vec_negx", 1'b1, -16384, 0, 0, TOL, lat);
        txn("vec_sat", 1'b1, 32767, 32767, 0, 0, lat);

        for (int k = 0; k < 24; k++) begin
            xi = int'($urandom_range(0, 40000)) - 20000;
            yi = int'($urandom_range(0, 40000)) - 20000;
            ph = int'($urandom_range(0, 65535)) - 32768;
            txn("rot_rand", 1'b0, xi, yi, ph, TOL, lat);
        end
        for (int k = 0; k < 24; k++) begin
            xi = 12000; yi = -9000;
            for (int t = 0; t < 50; t++) begin
                xi = int'($urandom_range(0, 46000)) - 23000;
                yi = int'($urandom_range(0, 46000)) - 23000;
                if (xi * xi + yi * yi >= 8192 * 8192) break;
                xi = 12000; yi = -9000;
            end
            txn("vec_rand", 1'b1, xi, yi, 0, TOL, lat);
        end

        // Output backpressure: result held, busy input ignored
        out_ready = 1'b0;
        model(1'b0, 16'h2000, 16'h1000, 16'h6000, ex, ey, ez);
        send(1'b0, 16'h2000, 16'h1000, 16'h6000);
        wait_out(lat, ok);
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            mode     = 1'b1;
            x_in     = WIDTH'($urandom);
            y_in     = WIDTH'($urandom);
            @(posedge clk);
            @(negedge clk);
            chk("hold_valid", int'(out_valid), 1, 0, 1'b0);
            chk("hold_in_ready", int'(in_ready), 0, 0, 1'b0);
            chk("hold_x", int'($signed(x_out)), ex, TOL, 1'b0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("release_in_ready", int'(in_ready), 1, 0, 1'b0);
        chk("release_out_valid", int'(out_valid), 0, 0, 1'b0);
        chk("release_keep_y", int'($signed(y_out)), ey, TOL, 1'b0);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("idle_after_release", int'(in_ready), 1, 0, 1'b0);

        // Asynchronous reset in the middle of the iterations
        send(1'b0, 16'h4000, 0, 16'h2000);
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_in_ready", int'(in_ready), 1, 0, 1'b0);
        chk("arst_out_valid", int'(out_valid), 0, 0, 1'b0);
        chk("arst_x_out", int'(x_out), 0, 0, 1'b0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("no_stale_result", int'(seen), 0, 0, 1'b0);
        txn("post_rst", 1'b1, 16'h3000, 16'h4000, 0, TOL, lat);
        chk("post_rst_latency", lat, ITERS + 2, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
